// File: rtl/tc_ps_gp_wr_ctl.sv
// rtl/tc_ps_gp_wr_ctl.sv - AXI3 GP0 write slave bridging each W beat to a local register-bus write
module tc_ps_gp_wr_ctl #(
  parameter int WR_GAP    = 0,
  parameter bit CHK_WLAST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] addr,
  output logic [31:0] data,
  output logic [3:0]  be,
  output logic        wren,
  input  logic [31:0] M_AXI_GP0_0_awaddr,
  input  logic [1:0]  M_AXI_GP0_0_awburst,
  input  logic [11:0] M_AXI_GP0_0_awid,
  input  logic [3:0]  M_AXI_GP0_0_awlen,
  input  logic [2:0]  M_AXI_GP0_0_awsize,
  input  logic [3:0]  M_AXI_GP0_0_awcache,
  input  logic [1:0]  M_AXI_GP0_0_awlock,
  input  logic [2:0]  M_AXI_GP0_0_awprot,
  input  logic [3:0]  M_AXI_GP0_0_awqos,
  input  logic        M_AXI_GP0_0_awvalid,
  output logic        M_AXI_GP0_0_awready,
  input  logic [31:0] M_AXI_GP0_0_wdata,
  input  logic [3:0]  M_AXI_GP0_0_wstrb,
  input  logic [11:0] M_AXI_GP0_0_wid,
  input  logic        M_AXI_GP0_0_wlast,
  input  logic        M_AXI_GP0_0_wvalid,
  output logic        M_AXI_GP0_0_wready,
  output logic [11:0] M_AXI_GP0_0_bid,
  output logic [1:0]  M_AXI_GP0_0_bresp,
  output logic        M_AXI_GP0_0_bvalid,
  input  logic        M_AXI_GP0_0_bready
);

  typedef enum logic [2:0] {
    S_CMPT  = 3'd0,
    S_IDLE  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam logic [3:0] GAP = 4'(WR_GAP);

  state_t      r_state;
  logic        r_awready;
  logic        r_wready;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic [11:0] r_bid;
  logic [11:0] r_id;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [3:0]  r_be;
  logic        r_wren;
  logic [31:0] r_cur_addr;
  logic [3:0]  r_len;
  logic [1:0]  r_burst;
  logic [3:0]  r_beat;
  logic        r_err;
  logic [3:0]  r_gap;

  logic [31:0] w_mask;
  logic        w_wrap_ok;
  logic [31:0] w_next_addr;
  logic        w_last_beat;
  logic        w_unused;

  // Size, cache/lock/prot/qos and wid carry nothing this bridge can act on.
  assign w_unused = ^{M_AXI_GP0_0_awsize, M_AXI_GP0_0_awcache, M_AXI_GP0_0_awlock,
                      M_AXI_GP0_0_awprot, M_AXI_GP0_0_awqos, M_AXI_GP0_0_wid};

  assign w_last_beat = (r_beat == r_len);
  assign w_mask      = ((32'(r_len) + 32'd1) << 2) - 32'd1;
  assign w_wrap_ok   = (r_len == 4'd1) || (r_len == 4'd3) || (r_len == 4'd7) || (r_len == 4'd15);

  // Illegal WRAP lengths fall back to INCR rather than erroring.
  always_comb begin
    w_next_addr = r_cur_addr + 32'd4;
    if (r_burst == 2'b00) begin
      w_next_addr = r_cur_addr;
    end else if (r_burst == 2'b10 && w_wrap_ok) begin
      w_next_addr = (r_cur_addr & ~w_mask) | ((r_cur_addr + 32'd4) & w_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_CMPT;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= 2'b00;
      r_bid      <= 12'd0;
      r_id       <= 12'd0;
      r_addr     <= 32'd0;
      r_data     <= 32'd0;
      r_be       <= 4'd0;
      r_wren     <= 1'b0;
      r_cur_addr <= 32'd0;
      r_len      <= 4'd0;
      r_burst    <= 2'b00;
      r_beat     <= 4'd0;
      r_err      <= 1'b0;
      r_gap      <= 4'd0;
    end else begin
      case (r_state)
        S_CMPT: begin
          r_awready <= 1'b1;
          r_state   <= S_IDLE;
        end
        S_IDLE: begin
          if (M_AXI_GP0_0_awvalid) begin
            r_awready  <= 1'b0;
            r_id       <= M_AXI_GP0_0_awid;
            r_cur_addr <= M_AXI_GP0_0_awaddr;
            r_len      <= M_AXI_GP0_0_awlen;
            r_burst    <= M_AXI_GP0_0_awburst;
            r_beat     <= 4'd0;
            r_err      <= 1'b0;
            r_wready   <= 1'b1;
            r_state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (M_AXI_GP0_0_wvalid) begin
            r_wready <= 1'b0;
            r_addr   <= r_cur_addr;
            r_data   <= M_AXI_GP0_0_wdata;
            r_be     <= M_AXI_GP0_0_wstrb;
            r_wren   <= 1'b1;
            if (CHK_WLAST && (M_AXI_GP0_0_wlast != w_last_beat)) begin
              r_err <= 1'b1;
            end
            r_gap   <= GAP;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_wren <= 1'b0;
          if (r_gap != 4'd0) begin
            r_gap <= r_gap - 4'd1;
          end else if (w_last_beat) begin
            r_bvalid <= 1'b1;
            r_bresp  <= r_err ? 2'b10 : 2'b00;
            r_bid    <= r_id;
            r_state  <= S_RESP;
          end else begin
            r_beat     <= r_beat + 4'd1;
            r_cur_addr <= w_next_addr;
            r_wready   <= 1'b1;
            r_state    <= S_DATA;
          end
        end
        S_RESP: begin
          if (M_AXI_GP0_0_bready) begin
            r_bvalid <= 1'b0;
            r_state  <= S_CMPT;
          end
        end
        default: r_state <= S_CMPT;
      endcase
    end
  end

  assign addr                = r_addr;
  assign data                = r_data;
  assign be                  = r_be;
  assign wren                = r_wren;
  assign M_AXI_GP0_0_awready = r_awready;
  assign M_AXI_GP0_0_wready  = r_wready;
  assign M_AXI_GP0_0_bid     = r_bid;
  assign M_AXI_GP0_0_bresp   = r_bresp;
  assign M_AXI_GP0_0_bvalid  = r_bvalid;

endmodule

// File: doc/tc_ps_gp_wr_ctl.md
Name: tc_ps_gp_wr_ctl

Overview:
- AXI3 write-channel slave on the PS M_AXI_GP0 port; the write-side counterpart of the GP read controller.
- Accepts AW/W/B transactions from the PS, including bursts of up to 16 beats.
- Converts each data beat into a single-cycle local register-bus write (addr/data/be/wren).
- Returns one B response per burst.
- Services one transaction at a time, with no outstanding-transaction overlap.

Parameters:
- WR_GAP, 0: extra idle cycles inserted after each wren pulse before wready is re-asserted (0..15).
- CHK_WLAST, 1: when 1, a WLAST/beat-count mismatch makes BRESP = SLVERR (2'b10).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- addr  out  32  local write address
- data  out  32  local write data
- be  out  4  local byte enables (copy of WSTRB)
- wren  out  1  local write strobe, one-cycle pulse per beat
- M_AXI_GP0_0_awaddr  in  32  burst start address
- M_AXI_GP0_0_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 treated as INCR
- M_AXI_GP0_0_awid  in  12  transaction ID
- M_AXI_GP0_0_awlen  in  4  beats minus 1
- M_AXI_GP0_0_awsize  in  3  ignored; beats are always 4 bytes
- M_AXI_GP0_0_awcache/awlock/awprot/awqos  in  4/2/3/4  ignored
- M_AXI_GP0_0_awvalid  in  1  AW valid
- M_AXI_GP0_0_awready  out  1  AW ready
- M_AXI_GP0_0_wdata  in  32  write data
- M_AXI_GP0_0_wstrb  in  4  byte strobes
- M_AXI_GP0_0_wid  in  12  ignored
- M_AXI_GP0_0_wlast  in  1  last beat
- M_AXI_GP0_0_wvalid  in  1  W valid
- M_AXI_GP0_0_wready  out  1  W ready
- M_AXI_GP0_0_bid  out  12  response ID (= latched awid)
- M_AXI_GP0_0_bresp  out  2  00 OKAY / 10 SLVERR
- M_AXI_GP0_0_bvalid  out  1  B valid
- M_AXI_GP0_0_bready  in  1  B ready

Behaviour:

Clock and reset:
- Clock clk. Reset rst is synchronous and active-high.
- On reset, every output and internal register goes to 0 and state goes to S_CMPT.
- The first awready=1 appears 1 cycle after rst deasserts.
- Reset mid-burst abandons the transaction: no further wren, and no B response is issued.

All outputs are registered.

States:
- S_CMPT: awready<=1; go to S_IDLE.
- S_IDLE: awready=1. On awvalid:
  - awready<=0.
  - Latch awid, awaddr (into cur_addr), awlen, awburst.
  - beat<=0, err<=0, wready<=1; go to S_DATA.
- S_DATA: wready=1. On wvalid:
  - wready<=0.
  - addr<=cur_addr, data<=wdata, be<=wstrb, wren<=1.
  - If CHK_WLAST and wlast != (beat==len), set err<=1.
  - Go to S_WRITE; load gap counter with WR_GAP.
- S_WRITE: wren<=0 on entry cycle (wren is high for exactly 1 cycle).
  - Wait until the gap counter reaches 0.
  - If beat==len: bvalid<=1, bresp<=err?2'b10:2'b00, bid<=latched id; go to S_RESP.
  - Else: beat<=beat+1, cur_addr<=next address, wready<=1; go to S_DATA.
- S_RESP: hold bvalid/bresp/bid stable until bready; then bvalid<=0, go to S_CMPT.

Next address:
- FIXED: unchanged.
- INCR and 11: cur_addr+4, 32-bit wrap-around.
- WRAP: mask=((len+1)<<2)-1; next=(cur_addr & ~mask) | ((cur_addr+4) & mask). Legal len values are 1/3/7/15; any other len behaves as INCR.

Handshakes and timing:
- awready and wready are never high simultaneously.
- wvalid before the AW handshake is ignored; wready stays 0 until AW is accepted.
- Minimum beat period is 2+WR_GAP cycles.
- A new AW is accepted no earlier than 2 cycles after the B handshake.
- Latency from the wvalid&wready edge to wren=1 is 1 cycle; addr/data/be are valid with wren and hold until the next beat.
- Strobes: be is passed through even when 0; wren still pulses.
- Early wlast (before beat==len): the burst continues to len+1 beats and err is set. A missing wlast on the final beat also sets err.
- bvalid is not dropped without bready; awvalid during S_RESP waits.

Test Plan:
- Single write: awaddr=0x40000010, awlen=0, awid=0x005, wdata=0xDEADBEEF, wstrb=F, wlast=1 -> one wren pulse with addr=0x40000010, data=0xDEADBEEF, be=F; then bvalid with bid=0x005, bresp=00.
- INCR burst: awaddr=0x100, awlen=3, data 1..4, wlast on beat 4 -> wren at addr 0x100,0x104,0x108,0x10C with data 1..4; exactly one B, OKAY.
- WRAP burst: awaddr=0x208, awlen=3 -> addrs 0x208,0x20C,0x200,0x204. FIXED burst: awlen=2 -> three wren at the same addr.
- wlast asserted on beat 2 of awlen=3 with CHK_WLAST=1 -> 4 wren pulses, bresp=10. Repeat with CHK_WLAST=0 -> bresp=00.
- Backpressure: bready held low 10 cycles -> bvalid/bid stable, awready=0 despite awvalid. Beat spacing with WR_GAP=3 -> wren pulses 5 cycles apart.
- rst asserted after beat 2 of an 8-beat burst -> all outputs 0 next cycle, no B response; a fresh single write afterwards completes normally.
